function_using_decoder: RTL and testbench

- Implements three 3-variable Boolean functions as sums of minterms taken from a 3-to-8 line decoder with enable.
- Default functions form a full adder/subtractor: f1 is sum/difference, f2 is carry, f3 is borrow.
- Decoder lines and function results are registered; the block is a small arithmetic/logic leaf used in combinational-decoder exercises.
- Clocked with an asynchronous active-low reset.

---
 rtl/function_using_decoder.sv | 87 ++++++++
 tb/tb_function_using_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/function_using_decoder.sv
// Three 3-input Boolean functions built as minterm sums from a registered 3-to-8 decoder.
// Optional one-hot integrity monitor (err output) enabled by defining FUNC_ONEHOT_CHECK_EN.
module function_using_decoder #(
   parameter logic [7:0] F1_MASK = 8'h96,
   parameter logic [7:0] F2_MASK = 8'hE8,
   parameter logic [7:0] F3_MASK = 8'h8E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       e,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   output logic [7:0] y,
   output logic       f1,
   output logic       f2,
   output logic       f3
`ifdef FUNC_ONEHOT_CHECK_EN
   ,
   output logic       err
`endif
);

   // No handshake: inputs are sampled on every rising edge and the
   // outputs reflect them exactly one cycle later.
   logic [2:0] idx;
   logic [7:0] y_d, y_q;
   logic       f1_d, f1_q;
   logic       f2_d, f2_q;
   logic       f3_d, f3_q;

   always_comb begin
      idx  = {a, b, c};
      y_d  = e ? (8'h01 << idx) : 8'h00;
      f1_d = |(y_d & F1_MASK);
      f2_d = |(y_d & F2_MASK);
      f3_d = |(y_d & F3_MASK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q  <= 8'h00;
         f1_q <= 1'b0;
         f2_q <= 1'b0;
         f3_q <= 1'b0;
      end else begin
         y_q  <= y_d;
         f1_q <= f1_d;
         f2_q <= f2_d;
         f3_q <= f3_d;
      end
   end

   assign y  = y_q;
   assign f1 = f1_q;
   assign f2 = f2_q;
   assign f3 = f3_q;

`ifdef FUNC_ONEHOT_CHECK_EN
   // en_q tracks which enable produced the current y_q, so the check
   // compares the registered lines against the enable that created them.
   logic en_d, en_q;
   logic err_d, err_q;
   logic y_onehot;
   logic viol;

   always_comb begin
      en_d     = e;
      y_onehot = (y_q != 8'h00) && ((y_q & (y_q - 8'h01)) == 8'h00);
      viol     = en_q ? !y_onehot : (y_q != 8'h00);
      err_d    = err_q | viol;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         en_q  <= en_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_function_using_decoder.sv
// Directed bench for function_using_decoder: default masks plus a second instance with edge-case masks.
module tb_function_using_decoder;

   logic       clk;
   logic       rst_n;
   logic       e, a, b, c;
   logic [7:0] y, y_m;
   logic       f1, f2, f3;
   logic       f1_m, f2_m, f3_m;
`ifdef FUNC_ONEHOT_CHECK_EN
   logic       err, err_m;
`endif

   int n_cmp;
   int n_bad;

   function_using_decoder u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .e     (e),
      .a     (a),
      .b     (b),
      .c     (c),
      .y     (y),
      .f1    (f1),
      .f2    (f2),
      .f3    (f3)
`ifdef FUNC_ONEHOT_CHECK_EN
      ,
      .err   (err)
`endif
   );

   // Boundary masks: empty, full, and a single minterm.
   function_using_decoder #(
      .F1_MASK (8'h00),
      .F2_MASK (8'hFF),
      .F3_MASK (8'h01)
   ) u_dut_m (
      .clk   (clk),
      .rst_n (rst_n),
      .e     (e),
      .a     (a),
      .b     (b),
      .c     (c),
      .y     (y_m),
      .f1    (f1_m),
      .f2    (f2_m),
      .f3    (f3_m)
`ifdef FUNC_ONEHOT_CHECK_EN
      ,
      .err   (err_m)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive(input logic ei, input logic [2:0] idx);
      e = ei;
      {a, b, c} = idx;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      drive(1'b1, 3'd7);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({y, f1, f2, f3} !== 11'h000) begin
         n_bad++;
         $display("FAIL reset_immediate: got y=%h f=%b%b%b want y=00 f=000", y, f1, f2, f3);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({y, f1, f2, f3} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: got y=%h f=%b%b%b want y=00 f=000", i, y, f1, f2, f3);
         end
      end
`ifdef FUNC_ONEHOT_CHECK_EN
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_err: got %b want 0", err);
      end
`endif
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h80, 3'b111}) begin
         n_bad++;
         $display("FAIL reset_release: got y=%h f=%b%b%b want y=80 f=111", y, f1, f2, f3);
      end
   endtask

   task automatic test_enabled_sweep();
      logic [7:0] y_exp [8];
      logic       f1_exp[8];
      logic       f2_exp[8];
      logic       f3_exp[8];
      y_exp  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      f1_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      f2_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      f3_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i));
         tick();
         n_cmp++;
         if ({y, f1, f2, f3} !== {y_exp[i], f1_exp[i], f2_exp[i], f3_exp[i]}) begin
            n_bad++;
            $display("FAIL en_sweep[%0d]: got y=%h f=%b%b%b want y=%h f=%b%b%b", i, y, f1, f2, f3,
                     y_exp[i], f1_exp[i], f2_exp[i], f3_exp[i]);
         end
         n_cmp++;
         if ({y_m, f1_m, f2_m, f3_m} !== {y_exp[i], 1'b0, 1'b1, (i == 0)}) begin
            n_bad++;
            $display("FAIL mask_en_sweep[%0d]: got y=%h f=%b%b%b want y=%h f=01%b", i, y_m, f1_m,
                     f2_m, f3_m, y_exp[i], (i == 0));
         end
      end
   endtask

   task automatic test_disabled_sweep();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 3'(i));
         tick();
         n_cmp++;
         if ({y, f1, f2, f3} !== 11'h000) begin
            n_bad++;
            $display("FAIL dis_sweep[%0d]: got y=%h f=%b%b%b want y=00 f=000", i, y, f1, f2, f3);
         end
         n_cmp++;
         if ({y_m, f1_m, f2_m, f3_m} !== 11'h000) begin
            n_bad++;
            $display("FAIL mask_dis_sweep[%0d]: got y=%h f=%b%b%b want y=00 f=000", i, y_m, f1_m,
                     f2_m, f3_m);
         end
      end
   endtask

   task automatic test_latency();
      drive(1'b1, 3'd3);
      tick();
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h08, 3'b011}) begin
         n_bad++;
         $display("FAIL lat_idx3: got y=%h f=%b%b%b want y=08 f=011", y, f1, f2, f3);
      end
      drive(1'b1, 3'd4);
      #1;
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h08, 3'b011}) begin
         n_bad++;
         $display("FAIL lat_hold: got y=%h f=%b%b%b want y=08 f=011", y, f1, f2, f3);
      end
      tick();
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h10, 3'b100}) begin
         n_bad++;
         $display("FAIL lat_idx4: got y=%h f=%b%b%b want y=10 f=100", y, f1, f2, f3);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 3'd5);
      tick();
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h20, 3'b010}) begin
         n_bad++;
         $display("FAIL arst_pre: got y=%h f=%b%b%b want y=20 f=010", y, f1, f2, f3);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({y, f1, f2, f3} !== 11'h000) begin
         n_bad++;
         $display("FAIL arst_now: got y=%h f=%b%b%b want y=00 f=000", y, f1, f2, f3);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({y, f1, f2, f3} !== {8'h20, 3'b010}) begin
         n_bad++;
         $display("FAIL arst_reload: got y=%h f=%b%b%b want y=20 f=010", y, f1, f2, f3);
      end
   endtask

`ifdef FUNC_ONEHOT_CHECK_EN
   task automatic test_onehot_check();
      n_cmp++;
      if (err !== 1'b0 || err_m !== 1'b0) begin
         n_bad++;
         $display("FAIL err_legal: got %b/%b want 0/0", err, err_m);
      end
      drive(1'b1, 3'd2);
      tick();
      force u_dut.y_q = 8'h06;
      tick();
      release u_dut.y_q;
      tick();
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_set: got %b want 1", err);
      end
      tick();
      tick();
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: got %b want 1", err);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: got %b want 0", err);
      end
      rst_n = 1'b1;
      tick();
   endtask
`endif

   // final report
   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b1;
      drive(1'b0, 3'd0);
      test_reset();
      test_enabled_sweep();
      test_disabled_sweep();
      test_latency();
      test_async_reset();
`ifdef FUNC_ONEHOT_CHECK_EN
      test_onehot_check();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
